// File: rtl/ex_mem_wb_backend.sv
// Back end of the 5-stage pipeline: EX/MEM register, combinational MEM stage
// (data RAM load/store and result select) and MEM/WB register.
module ex_mem_wb_backend (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [4:0]  ex_wd_i,
  input  logic        ex_wreg_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [2:0]  ex_memop_i,
  input  logic [31:0] ex_maddr_i,
  input  logic [31:0] ex_sdata_i,
  input  logic [31:0] ram_rdata_i,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_sel_o,
  output logic        ram_we_o,
  output logic        ram_ce_o,
  output logic [4:0]  mem_wd_o,
  output logic        mem_wreg_o,
  output logic [31:0] mem_wdata_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o
);

  localparam logic [2:0] OP_LW  = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_SW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;

  function automatic logic [31:0] load_byte(input logic [31:0] word,
                                            input logic [1:0]  off,
                                            input logic        sext);
    logic [7:0] b;
    b = word[{off, 3'b000} +: 8];
    load_byte = sext ? {{24{b[7]}}, b} : {24'h000000, b};
  endfunction

  logic [4:0]  wd_p1_q, wd_p1_d;
  logic        wreg_p1_q, wreg_p1_d;
  logic [31:0] wdata_p1_q, wdata_p1_d;
  logic [2:0]  memop_p1_q, memop_p1_d;
  logic [31:0] maddr_p1_q, maddr_p1_d;
  logic [31:0] sdata_p1_q, sdata_p1_d;
  logic [4:0]  wd_p2_q, wd_p2_d;
  logic        wreg_p2_q, wreg_p2_d;
  logic [31:0] wdata_p2_q, wdata_p2_d;
  logic [3:0]  byte_oh;

  // EX -> EX/MEM and MEM -> MEM/WB next-state; flush takes priority over stall
  always_comb begin
    wd_p1_d    = wd_p1_q;
    wreg_p1_d  = wreg_p1_q;
    wdata_p1_d = wdata_p1_q;
    memop_p1_d = memop_p1_q;
    maddr_p1_d = maddr_p1_q;
    sdata_p1_d = sdata_p1_q;
    wd_p2_d    = wd_p2_q;
    wreg_p2_d  = wreg_p2_q;
    wdata_p2_d = wdata_p2_q;
    if (flush_i) begin
      wd_p1_d    = '0;
      wreg_p1_d  = 1'b0;
      wdata_p1_d = '0;
      memop_p1_d = '0;
      maddr_p1_d = '0;
      sdata_p1_d = '0;
      wd_p2_d    = '0;
      wreg_p2_d  = 1'b0;
      wdata_p2_d = '0;
    end else if (!stall_i) begin
      wd_p1_d    = ex_wd_i;
      wreg_p1_d  = ex_wreg_i;
      wdata_p1_d = ex_wdata_i;
      memop_p1_d = ex_memop_i;
      maddr_p1_d = ex_maddr_i;
      sdata_p1_d = ex_sdata_i;
      wd_p2_d    = mem_wd_o;
      wreg_p2_d  = mem_wreg_o;
      wdata_p2_d = mem_wdata_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wd_p1_q    <= '0;
      wreg_p1_q  <= 1'b0;
      wdata_p1_q <= '0;
      memop_p1_q <= '0;
      maddr_p1_q <= '0;
      sdata_p1_q <= '0;
      wd_p2_q    <= '0;
      wreg_p2_q  <= 1'b0;
      wdata_p2_q <= '0;
    end else begin
      wd_p1_q    <= wd_p1_d;
      wreg_p1_q  <= wreg_p1_d;
      wdata_p1_q <= wdata_p1_d;
      memop_p1_q <= memop_p1_d;
      maddr_p1_q <= maddr_p1_d;
      sdata_p1_q <= sdata_p1_d;
      wd_p2_q    <= wd_p2_d;
      wreg_p2_q  <= wreg_p2_d;
      wdata_p2_q <= wdata_p2_d;
    end
  end

  // MEM stage (combinational from EX/MEM)
  assign byte_oh    = 4'b0001 << maddr_p1_q[1:0];
  assign ram_addr_o = {maddr_p1_q[31:2], 2'b00};

  always_comb begin
    mem_wd_o    = wd_p1_q;
    mem_wreg_o  = wreg_p1_q;
    mem_wdata_o = wdata_p1_q;
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_sel_o   = 4'b0000;
    ram_wdata_o = '0;
    case (memop_p1_q)
      OP_LW: begin
        ram_ce_o    = 1'b1;
        ram_sel_o   = 4'b1111;
        mem_wdata_o = ram_rdata_i;
      end
      OP_LB, OP_LBU: begin
        ram_ce_o    = 1'b1;
        ram_sel_o   = byte_oh;
        mem_wdata_o = load_byte(ram_rdata_i, maddr_p1_q[1:0], memop_p1_q == OP_LB);
      end
      OP_SW: begin
        ram_ce_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_sel_o   = 4'b1111;
        ram_wdata_o = sdata_p1_q;
        mem_wreg_o  = 1'b0;
      end
      OP_SB: begin
        ram_ce_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_sel_o   = byte_oh;
        ram_wdata_o = {4{sdata_p1_q[7:0]}};
        mem_wreg_o  = 1'b0;
      end
      default: ;
    endcase
  end

  // MEM/WB outputs
  assign wb_wd_o    = wd_p2_q;
  assign wb_wreg_o  = wreg_p2_q;
  assign wb_wdata_o = wdata_p2_q;

endmodule

// File: tb/tb_ex_mem_wb_backend.sv
// Directed bench for ex_mem_wb_backend: an instruction-level model checked on
// every falling edge, plus hand-computed literal expectations.
module tb_ex_mem_wb_backend;

  logic        clk, rst_n, stall, flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_maddr, ex_sdata, ram_rdata;
  logic [2:0]  ex_memop;
  logic [31:0] ram_addr, ram_wdata, mem_wdata, wb_wdata;
  logic [3:0]  ram_sel;
  logic        ram_we, ram_ce, mem_wreg, wb_wreg;
  logic [4:0]  mem_wd, wb_wd;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  ex_mem_wb_backend dut (
    .clk_i(clk), .rst_i(rst_n), .stall_i(stall), .flush_i(flush),
    .ex_wd_i(ex_wd), .ex_wreg_i(ex_wreg), .ex_wdata_i(ex_wdata),
    .ex_memop_i(ex_memop), .ex_maddr_i(ex_maddr), .ex_sdata_i(ex_sdata),
    .ram_rdata_i(ram_rdata), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_sel_o(ram_sel), .ram_we_o(ram_we), .ram_ce_o(ram_ce),
    .mem_wd_o(mem_wd), .mem_wreg_o(mem_wreg), .mem_wdata_o(mem_wdata),
    .wb_wd_o(wb_wd), .wb_wreg_o(wb_wreg), .wb_wdata_o(wb_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
  } instr_t;

  instr_t      m_mem;
  logic [4:0]  m_wb_wd;
  logic        m_wb_wreg;
  logic [31:0] m_wb_data;
  logic        m_wb_store;

  function automatic bit is_store(input instr_t i);
    return i.op == 3'd4 || i.op == 3'd5;
  endfunction

  function automatic bit is_access(input instr_t i);
    return i.op >= 3'd1 && i.op <= 3'd5;
  endfunction

  function automatic logic [31:0] model_result(input instr_t i, input logic [31:0] rd);
    logic [31:0] b;
    b = (rd >> (8 * i.addr[1:0])) & 32'hFF;
    case (i.op)
      3'd1:    return rd;
      3'd2:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd3:    return b;
      default: return i.wdata;
    endcase
  endfunction

  function automatic logic [3:0] model_sel(input instr_t i);
    if (i.op == 3'd1 || i.op == 3'd4) return 4'hF;
    if (is_access(i)) return 4'(1 << i.addr[1:0]);
    return 4'h0;
  endfunction

  function automatic logic [31:0] model_ram_wdata(input instr_t i);
    if (i.op == 3'd4) return i.sdata;
    if (i.op == 3'd5) return i.sdata[7:0] * 32'h0101_0101;
    return 32'h0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mem <= '0; m_wb_wd <= '0; m_wb_wreg <= 1'b0; m_wb_data <= '0; m_wb_store <= 1'b0;
    end else if (flush) begin
      m_mem <= '0; m_wb_wd <= '0; m_wb_wreg <= 1'b0; m_wb_data <= '0; m_wb_store <= 1'b0;
    end else if (!stall) begin
      m_wb_wd    <= m_mem.wd;
      m_wb_wreg  <= m_mem.wreg && !is_store(m_mem);
      m_wb_data  <= model_result(m_mem, ram_rdata);
      m_wb_store <= is_store(m_mem);
      m_mem      <= '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, op: ex_memop,
                      addr: ex_maddr, sdata: ex_sdata};
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("m_ram_ce", {31'b0, ram_ce}, {31'b0, is_access(m_mem)});
      chk("m_ram_we", {31'b0, ram_we}, {31'b0, is_store(m_mem)});
      chk("m_ram_sel", {28'b0, ram_sel}, {28'b0, model_sel(m_mem)});
      chk("m_ram_wdata", ram_wdata, model_ram_wdata(m_mem));
      if (is_access(m_mem)) chk("m_ram_addr", ram_addr, m_mem.addr & 32'hFFFF_FFFC);
      chk("m_mem_wd", {27'b0, mem_wd}, {27'b0, m_mem.wd});
      chk("m_mem_wreg", {31'b0, mem_wreg}, {31'b0, m_mem.wreg && !is_store(m_mem)});
      if (!is_store(m_mem)) chk("m_mem_wdata", mem_wdata, model_result(m_mem, ram_rdata));
      chk("m_wb_wd", {27'b0, wb_wd}, {27'b0, m_wb_wd});
      chk("m_wb_wreg", {31'b0, wb_wreg}, {31'b0, m_wb_wreg});
      if (!m_wb_store) chk("m_wb_wdata", wb_wdata, m_wb_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata);
    ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ex_memop = op; ex_maddr = addr; ex_sdata = sdata;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ram_addr"}, ram_addr, 32'h0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    chk({tag, "_ram_ctl"}, {26'b0, ram_sel, ram_we, ram_ce}, 32'h0);
    chk({tag, "_mem_ctl"}, {26'b0, mem_wd, mem_wreg}, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_wb_ctl"}, {26'b0, wb_wd, wb_wreg}, 32'h0);
    chk({tag, "_wb_wdata"}, wb_wdata, 32'h0);
  endtask

  task automatic chk_mem(input string tag, input logic [4:0] wd, input logic wreg, input logic [31:0] d);
    chk({tag, "_mem_ctl"}, {26'b0, mem_wd, mem_wreg}, {26'b0, wd, wreg});
    chk({tag, "_mem_wdata"}, mem_wdata, d);
  endtask

  task automatic chk_wb(input string tag, input logic [4:0] wd, input logic wreg, input logic [31:0] d);
    chk({tag, "_wb_ctl"}, {26'b0, wb_wd, wb_wreg}, {26'b0, wd, wreg});
    chk({tag, "_wb_wdata"}, wb_wdata, d);
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; ram_rdata = '0;
    issue(5'd9, 1'b1, 32'h1234, 3'd4, 32'h40, 32'h5555);
    #2 rst_n = 1'b0;
    #1 all_zero("rst_async");
    tick(); tick();
    issue(5'd0, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Basic latency
    issue(5'd1, 1'b1, 32'h1, 3'd0, 32'h0, 32'h0);
    tick(); chk_mem("lat1", 5'd1, 1'b1, 32'h1); chk_wb("lat1", 5'd0, 1'b0, 32'h0);
    issue(5'd0, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0);
    tick(); chk_wb("lat2", 5'd1, 1'b1, 32'h1); chk_mem("lat2", 5'd0, 1'b0, 32'h0);

    // Loads
    ram_rdata = 32'h8081_82F3;
    issue(5'd2, 1'b1, 32'h0, 3'd1, 32'h100, 32'h0);
    tick();
    chk("lw_sel", {28'b0, ram_sel}, 32'hF);
    chk("lw_addr", ram_addr, 32'h100);
    chk("lw_data", mem_wdata, 32'h8081_82F3);
    issue(5'd3, 1'b1, 32'h0, 3'd2, 32'h100, 32'h0);
    tick();
    chk("lw_wb", wb_wdata, 32'h8081_82F3);
    chk("lb_sel", {28'b0, ram_sel}, 32'h1);
    chk("lb_data", mem_wdata, 32'hFFFF_FFF3);
    issue(5'd4, 1'b1, 32'h0, 3'd3, 32'h103, 32'h0);
    tick();
    chk("lb_wb", wb_wdata, 32'hFFFF_FFF3);
    chk("lbu_sel", {28'b0, ram_sel}, 32'h8);
    chk("lbu_addr", ram_addr, 32'h100);
    chk("lbu_data", mem_wdata, 32'h0000_0080);
    issue(5'd0, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0);
    tick();
    chk("lbu_wb", wb_wdata, 32'h0000_0080);

    // Stores
    issue(5'd6, 1'b1, 32'h55, 3'd4, 32'h20, 32'hDEAD_BEEF);
    tick();
    chk("sw_ctl", {28'b0, ram_sel, ram_we, ram_ce}, {26'b0, 4'hF, 1'b1, 1'b1});
    chk("sw_wdata", ram_wdata, 32'hDEAD_BEEF);
    chk("sw_mem_wreg", {31'b0, mem_wreg}, 32'h0);
    issue(5'd7, 1'b1, 32'h66, 3'd5, 32'h22, 32'h1234_5678);
    tick();
    chk("sw_wb_wreg", {31'b0, wb_wreg}, 32'h0);
    chk("sb_sel", {28'b0, ram_sel}, 32'h4);
    chk("sb_wdata", ram_wdata, 32'h7878_7878);
    chk("sb_addr", ram_addr, 32'h20);
    issue(5'd0, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0);
    tick();
    chk("sb_wb_wreg", {31'b0, wb_wreg}, 32'h0);

    // Stall (with a held store in MEM)
    issue(5'd7, 1'b1, 32'h77, 3'd0, 32'h0, 32'h0);
    tick();
    issue(5'd8, 1'b1, 32'h88, 3'd4, 32'h30, 32'hCAFE_F00D);
    tick(); chk_wb("pre_stall", 5'd7, 1'b1, 32'h77);
    stall = 1'b1;
    issue(5'd9, 1'b1, 32'h99, 3'd0, 32'h0, 32'h0);
    tick(); tick();
    chk_wb("stall", 5'd7, 1'b1, 32'h77);
    chk("stall_we", {31'b0, ram_we}, 32'h1);
    chk("stall_wdata", ram_wdata, 32'hCAFE_F00D);
    stall = 1'b0;
    tick(); chk_mem("unstall", 5'd9, 1'b1, 32'h99); chk_wb("unstall", 5'd8, 1'b0, wb_wdata);
    tick(); chk_wb("unstall2", 5'd9, 1'b1, 32'h99);

    // Flush
    issue(5'd10, 1'b1, 32'hAA, 3'd0, 32'h0, 32'h0);
    tick(); chk_mem("pre_flush", 5'd10, 1'b1, 32'hAA);
    flush = 1'b1;
    issue(5'd11, 1'b1, 32'hBB, 3'd0, 32'h0, 32'h0);
    tick(); chk_mem("flush", 5'd0, 1'b0, 32'h0); chk_wb("flush", 5'd0, 1'b0, 32'h0);
    flush = 1'b0;

    // Stall and flush together
    issue(5'd12, 1'b1, 32'hCC, 3'd0, 32'h0, 32'h0);
    tick();
    stall = 1'b1; flush = 1'b1;
    issue(5'd13, 1'b1, 32'hDD, 3'd0, 32'h0, 32'h0);
    tick(); chk_mem("stfl", 5'd0, 1'b0, 32'h0); chk_wb("stfl", 5'd0, 1'b0, 32'h0);
    stall = 1'b0; flush = 1'b0;

    // Back-to-back ALU results
    issue(5'd3, 1'b1, 32'hA, 3'd0, 32'h0, 32'h0);
    tick();
    issue(5'd4, 1'b1, 32'hB, 3'd0, 32'h0, 32'h0);
    tick(); chk_wb("b2b0", 5'd3, 1'b1, 32'hA);
    issue(5'd5, 1'b1, 32'hC, 3'd0, 32'h0, 32'h0);
    tick(); chk_wb("b2b1", 5'd4, 1'b1, 32'hB);
    issue(5'd0, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0);
    tick(); chk_wb("b2b2", 5'd5, 1'b1, 32'hC);
    tick(); chk_wb("b2b3", 5'd0, 1'b0, 32'h0);

    // Mid-run asynchronous reset
    issue(5'd14, 1'b1, 32'hEE, 3'd0, 32'h0, 32'h0);
    tick();
    issue(5'd15, 1'b1, 32'hFF, 3'd4, 32'h44, 32'h1111_2222);
    tick(); chk_wb("pre_rst", 5'd14, 1'b1, 32'hEE);
    #2 rst_n = 1'b0;
    #1 all_zero("rst_mid");
    tick(); all_zero("rst_held");
    issue(5'd16, 1'b1, 32'h16, 3'd0, 32'h0, 32'h0);
    rst_n = 1'b1;
    tick(); chk_mem("refill", 5'd16, 1'b1, 32'h16); chk_wb("refill", 5'd0, 1'b0, 32'h0);
    issue(5'd0, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0);
    tick(); chk_wb("refill2", 5'd16, 1'b1, 32'h16);

    tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_wb_backend.md
Name: ex_mem_wb_backend

Overview:
Back end of the 5-stage CPU pipeline. It contains the EX/MEM pipeline register, the combinational MEM stage (load/store access to data RAM, result selection) and the MEM/WB pipeline register. It sits between the EX stage and the register-file write port. It also exports MEM-stage results for forwarding.

Parameters:
none (widths fixed: 32-bit data/address, 5-bit register index)

Ports:
clk_i  in  1  system clock, all registers on rising edge
rst_i  in  1  asynchronous, active-low reset (0 = reset)
stall_i  in  1  hold both pipeline registers
flush_i  in  1  load bubble (all-zero) into both pipeline registers
ex_wd_i  in  5  destination register index from EX
ex_wreg_i  in  1  register-write enable from EX
ex_wdata_i  in  32  ALU result from EX
ex_memop_i  in  3  0=none 1=LW 2=LB 3=LBU 4=SW 5=SB (6,7 treated as none)
ex_maddr_i  in  32  byte address for load/store
ex_sdata_i  in  32  store data
ram_rdata_i  in  32  data RAM read word (combinational)
ram_addr_o  out  32  RAM word address (maddr with [1:0] cleared)
ram_wdata_o  out  32  RAM write data
ram_sel_o  out  4  byte enables, bit k = byte k (little-endian)
ram_we_o  out  1  RAM write strobe
ram_ce_o  out  1  RAM access enable
mem_wd_o  out  5  MEM-stage destination (forwarding)
mem_wreg_o  out  1  MEM-stage write enable (forwarding)
mem_wdata_o  out  32  MEM-stage result (forwarding)
wb_wd_o  out  5  write-back destination
wb_wreg_o  out  1  write-back enable
wb_wdata_o  out  32  write-back data

Behaviour:
- Reset (rst_i=0, asynchronous): every EX/MEM and MEM/WB register is cleared to 0, so all mem_* and wb_* outputs are 0 and all ram_* outputs are 0. This holds for the full duration of the reset, including mid-operation; it is not gated by the clock.
- EX/MEM register: on a rising edge it captures ex_wd_i, ex_wreg_i, ex_wdata_i, ex_memop_i, ex_maddr_i and ex_sdata_i.
- MEM stage, combinational from the EX/MEM register:
  - none: mem_wdata_o = wdata; ram_ce_o=0, ram_we_o=0, ram_sel_o=0.
  - LW: ram_ce_o=1, ram_sel_o=1111; mem_wdata_o = ram_rdata_i. Low address bits are ignored (no misalignment exception).
  - LB/LBU: ram_ce_o=1; ram_sel_o is one-hot at maddr[1:0]. The selected byte ram_rdata_i[8k+7:8k] is sign-extended (LB) or zero-extended (LBU).
  - SW: ram_ce_o=1, ram_we_o=1, ram_sel_o=1111, ram_wdata_o = sdata.
  - SB: ram_ce_o=1, ram_we_o=1; ram_sel_o is one-hot at maddr[1:0]; ram_wdata_o = sdata[7:0] replicated in all 4 bytes.
  - Stores force mem_wreg_o=0. Otherwise mem_wreg_o and mem_wd_o pass through.
  - ram_wdata_o = 0 when not storing.
- MEM/WB register: on a rising edge it captures mem_wd_o, mem_wreg_o and mem_wdata_o into the wb_* outputs.
- Latency: EX inputs present before edge N appear on mem_* after edge N and on wb_* after edge N+1. Throughput is one instruction per cycle.
- stall_i=1: both registers hold their values. RAM outputs stay stable; a held store re-asserts its write, and the RAM tolerates this as idempotent.
- flush_i=1: both registers load 0 on the edge.
- flush_i and stall_i both set: flush wins.
- Register index 0 receives no special treatment; the register file ignores writes to it.

Test Plan:
- Reset then release: rst_i=0 -> all outputs 0 immediately, without a clock edge. Release, drive ex_wd_i=1, ex_wreg_i=1, ex_wdata_i=1, memop=0 -> mem_* = (1,1,1) after 1 edge; wb_* = (1,1,1) after 2 edges.
- Mid-run reset: assert rst_i=0 between edges while wb_* are nonzero -> wb_*, mem_*, ram_* go 0 asynchronously. Release -> pipeline refills with a 2-edge latency.
- Loads: ram_rdata_i=0x8081_82F3.
  - LW addr 0x100 -> wb_wdata=0x808182F3, sel=1111.
  - LB addr 0x100 -> 0xFFFFFFF3, sel=0001.
  - LBU addr 0x103 -> 0x00000080, sel=1000.
- Stores:
  - SW addr 0x20, sdata 0xDEADBEEF -> ram_we=1, sel=1111, wdata=0xDEADBEEF, mem_wreg=0, wb_wreg=0 next edge.
  - SB addr 0x22, sdata 0x12345678 -> sel=0100, wdata=0x78787878.
- Stall/flush:
  - Stall for 2 cycles with new EX inputs -> mem_*/wb_* unchanged; values resume after release.
  - Flush -> mem_* and wb_* = 0 on the next edge.
  - Stall+flush same cycle -> zeros.
- Back-to-back: 3 distinct ALU results on consecutive cycles (wd 3/4/5, data 0xA/0xB/0xC) -> wb_* shows each exactly one cycle, in order, 2 edges after issue.
